// File: rtl/fetch_mem_arbiter.sv
// Arbitrates the single instruction/data memory port between fetch and the LSU, with tagged read return.
// Optional ARB_PERF_CNT_EN adds fetch_stall_cnt, counting cycles in which fetch requests but is stopped.
module fetch_mem_arbiter #(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned MAX_LSU_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_stop,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_ack,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0]       fetch_stall_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_BURST);

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_LSU   = 2'd2
  } grant_t;

  grant_t                  grant;
  logic [STREAK_W-1:0]     lsu_streak;
  logic [MEM_LATENCY-1:0]  tag_valid;
  logic [MEM_LATENCY-1:0]  tag_lsu;
  logic [DATA_W-1:0]       fetch_hold;
  logic [DATA_W-1:0]       lsu_hold;
  logic                    issue_read;
  logic                    issue_lsu;
  logic                    ret_valid;

  // LSU has priority unless fetch has been held off for MAX_LSU_BURST consecutive grants.
  always_comb begin
    grant = GRANT_IDLE;
    if (!reset) begin
      if (lsu_req && !(fetch_req && (lsu_streak == STREAK_MAX))) begin
        grant = GRANT_LSU;
      end else if (fetch_req) begin
        grant = GRANT_FETCH;
      end
    end
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    lsu_ack    = 1'b0;
    fetch_stop = 1'b0;
    issue_read = 1'b0;
    issue_lsu  = 1'b0;
    case (grant)
      GRANT_LSU: begin
        mem_en     = 1'b1;
        mem_we     = lsu_we;
        mem_addr   = lsu_addr;
        mem_wdata  = lsu_wdata;
        lsu_ack    = 1'b1;
        fetch_stop = 1'b1;
        issue_read = !lsu_we;
        issue_lsu  = !lsu_we;
      end
      GRANT_FETCH: begin
        mem_en     = 1'b1;
        mem_addr   = fetch_addr;
        issue_read = 1'b1;
      end
      default: ;
    endcase
  end

  // Return routing straight from mem_rdata; the unselected output keeps its last value.
  always_comb begin
    ret_valid   = tag_valid[MEM_LATENCY-1] && !reset;
    fetch_valid = ret_valid && !tag_lsu[MEM_LATENCY-1];
    lsu_rvalid  = ret_valid && tag_lsu[MEM_LATENCY-1];
    fetch_data  = reset ? '0 : (fetch_valid ? mem_rdata : fetch_hold);
    lsu_rdata   = reset ? '0 : (lsu_rvalid ? mem_rdata : lsu_hold);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_hold <= '0;
      lsu_hold   <= '0;
    end else begin
      if (fetch_valid) fetch_hold <= mem_rdata;
      if (lsu_rvalid)  lsu_hold   <= mem_rdata;
    end
  end

  // Streak counts LSU grants only while fetch is waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      lsu_streak <= '0;
    end else if (!fetch_req || (grant == GRANT_FETCH)) begin
      lsu_streak <= '0;
    end else if ((grant == GRANT_LSU) && (lsu_streak != STREAK_MAX)) begin
      lsu_streak <= lsu_streak + STREAK_W'(1);
    end
  end

  // Tag pipeline tracks which requester owns each in-flight read.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_valid <= '0;
      tag_lsu   <= '0;
    end else begin
      tag_valid[0] <= issue_read;
      tag_lsu[0]   <= issue_lsu;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_lsu[i]   <= tag_lsu[i-1];
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_stall_cnt <= '0;
    end else if (fetch_req && fetch_stop) begin
      fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
Shares the single 16-bit instruction/data memory port between the fetch stage and the load/store unit (LSU).
- Issues at most one memory access per cycle.
- Tags each read and returns its data to the correct requester.
- Drives the fetch stage's stop input whenever fetch does not own the port.
- A starvation limit guarantees fetch progress under continuous LSU traffic.

Parameters:
ADDR_W, 20, word address width (matches the fetch program counter)
DATA_W, 16, memory word width
MEM_LATENCY, 1, cycles from issue (mem_en high) to mem_rdata valid; legal range 1..4
MAX_LSU_BURST, 4, max consecutive LSU grants while fetch_req is pending; legal range 1..15

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
fetch_req  in  1  fetch wants an instruction word
fetch_addr  in  ADDR_W  fetch program counter
fetch_data  out  DATA_W  returned instruction word
fetch_valid  out  1  fetch_data valid, 1-cycle pulse
fetch_stop  out  1  to the fetch stage stop input; holds the PC and fetch registers
lsu_req  in  1  LSU access request, held until lsu_ack
lsu_we  in  1  1 = write, 0 = read
lsu_addr  in  ADDR_W  LSU word address
lsu_wdata  in  DATA_W  write data
lsu_ack  out  1  request accepted this cycle; LSU may change inputs next cycle
lsu_rdata  out  DATA_W  read data
lsu_rvalid  out  1  lsu_rdata valid, 1-cycle pulse (reads only)
mem_en  out  1  access issued this cycle
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, MEM_LATENCY cycles after issue

Behaviour:
- Reset: every output is 0, the tag pipeline is cleared, and lsu_streak is 0.
- Reset mid-operation: in-flight reads are discarded. No fetch_valid or lsu_rvalid is produced for them.
- Grant decision is combinational each cycle:
  - lsu_req && !(fetch_req && lsu_streak == MAX_LSU_BURST) -> GRANT_LSU
  - else fetch_req -> GRANT_FETCH
  - else IDLE
- GRANT_LSU:
  - mem_en = 1, mem_we = lsu_we, mem_addr = lsu_addr, mem_wdata = lsu_wdata.
  - lsu_ack = 1.
  - fetch_stop = 1.
- GRANT_FETCH:
  - mem_en = 1, mem_we = 0, mem_addr = fetch_addr, mem_wdata = 0.
  - fetch_stop = 0.
- IDLE: mem_en = 0, mem_we = 0, fetch_stop = 0.
- lsu_streak (4-bit register):
  - Increments on GRANT_LSU while fetch_req is high, saturating at MAX_LSU_BURST.
  - Clears on GRANT_FETCH, or on any cycle where fetch_req is low.
- Tag pipeline: a MEM_LATENCY-deep shift register of {valid, is_lsu}.
  - A read issue inserts {1, grant==LSU}.
  - A write or IDLE inserts {0, 0}.
  - When the tail is valid, mem_rdata is routed to fetch_data (fetch_valid=1) or lsu_rdata (lsu_rvalid=1) in that cycle, combinationally from mem_rdata.
  - The data output not selected holds its last value.
- Ordering: returns arrive in issue order. At most one valid pulse per cycle across both requesters.
- Simultaneous lsu_req and fetch_req at reset release: LSU wins (streak 0).
- No fetch_req: LSU may be granted indefinitely with no starvation limit.
- lsu_req low during a valid tag return: the return is still delivered.
- fetch_stop only stalls the fetch stage. Branch and flush handling stay in the fetch stage.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds output fetch_stall_cnt [31:0]. It increments every cycle in which fetch_req && fetch_stop, clears on reset, and wraps at 2^32.
- Not defined: the port and counter are absent, with identical arbitration behaviour.

Test Plan:
- Reset held 3 cycles, then fetch_req=1 with fetch_addr=0x00010 and no LSU -> mem_en=1 and mem_addr=0x00010 on the first post-reset cycle; fetch_valid=1 with fetch_data=mem_rdata one cycle later (MEM_LATENCY=1); fetch_stop stays 0.
- fetch_req and lsu_req (read, lsu_addr=0x00200) both high -> lsu_ack=1, fetch_stop=1, mem_addr=0x00200 that cycle; lsu_rvalid=1 next cycle; fetch is granted the following cycle.
- lsu_req held for 10 cycles with fetch_req high, MAX_LSU_BURST=4 -> grant sequence L,L,L,L,F,L,L,L,L,F; fetch_stop pattern 1,1,1,1,0,1,1,1,1,0.
- LSU write (lsu_we=1, lsu_addr=0x00005, lsu_wdata=0xBEEF) -> mem_we=1, mem_wdata=0xBEEF; no lsu_rvalid and no fetch_valid for that slot.
- MEM_LATENCY=3, alternating fetch and LSU reads issued back-to-back -> valid pulses return 3 cycles after issue, in the same alternating order, each routed to the correct requester.
- Reset asserted one cycle after issuing two reads -> no fetch_valid or lsu_rvalid afterwards; all outputs 0 during reset. With ARB_PERF_CNT_EN, fetch_stall_cnt reads 0 after reset and 4 after the starvation scenario's first 4 cycles.
